duty_ramp_ctrl: RTL

Upstream stage of the half-bridge PWM block. Generates the 10-bit duty word `d_halfbridge` that the half-bridge consumes.
- Moves the duty toward a requested target by at most STEP counts per PWM period.
- Advances only on each rising edge of the PWM period interrupt (`clk_int`), so duty never changes mid-period.
- Provides a period-interrupt watchdog and a fault shutdown that forces duty to 0.

---
 rtl/dcmg_pkg.sv | 16 +
 rtl/edge_tick.sv | 22 ++
 rtl/duty_ramp_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dcmg_pkg.sv
// Shared definitions for the DCMG duty-path stages: duty width, FSM states
// and the default timing constants.
package dcmg_pkg;

    localparam int DUTY_W         = 10;
    localparam int PWM_PERIOD_CLK = 400;
    localparam int D_MAX_DEFAULT  = 900;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } dcmg_state_e;

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector: one-cycle pulse on the first clk where sig_i is high
// after being low. Usable by any DCMG stage that listens to a period interrupt.
module edge_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Duty ramp controller for the half-bridge PWM: slews d_halfbridge toward a
// clamped target once per PWM period, with watchdog and fault shutdown.
// Build option DUTY_RAMP_FAULT_LATCH_EN makes FAULT sticky until ce drops.
//
//   state | meaning
//   IDLE  | duty forced to 0, waiting for ce=1 and no fault
//   RAMP  | stepping toward target by at most STEP per tick
//   HOLD  | duty equals target, re-steps when target moves
//   FAULT | duty forced to 0, fault_flag high
module duty_ramp_ctrl
    import dcmg_pkg::*;
#(
    parameter int STEP         = 8,
    parameter int D_MAX        = D_MAX_DEFAULT,
    parameter int TICK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              clk_int,
    input  logic [DUTY_W-1:0] target_d,
    input  logic              fault,
    output logic [DUTY_W-1:0] d_halfbridge,
    output logic              ramp_done,
    output logic              fault_flag
);

    localparam int WD_W = $clog2(TICK_TIMEOUT + 1);

    localparam logic [DUTY_W-1:0] D_MAX_V   = DUTY_W'(D_MAX);
    localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   STEP_W    = (DUTY_W + 1)'(STEP);
    localparam logic [WD_W-1:0]   WD_TRIP   = WD_W'(TICK_TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_SATMAX = {WD_W{1'b1}};

    dcmg_state_e       state_q, state_d;
    logic [DUTY_W-1:0] d_q, d_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic              tick;
    logic [DUTY_W-1:0] tgt;
    logic signed [DUTY_W:0] diff;
    logic [DUTY_W:0]   diff_mag;
    logic [DUTY_W-1:0] d_step;
    logic              active;
    logic              wdog_trip;

    edge_tick u_edge_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (clk_int),
        .rise_o (tick)
    );

    assign tgt = (target_d > D_MAX_V) ? D_MAX_V : target_d;

    // Both operands are below 2^DUTY_W, so the 11-bit signed difference is exact.
    assign diff     = $signed({1'b0, tgt}) - $signed({1'b0, d_q});
    assign diff_mag = diff[DUTY_W] ? DUTY_W'(0) - diff : diff;

    // When the gap exceeds STEP, d +/- STEP stays strictly between d and tgt,
    // so neither 0 nor D_MAX can be crossed.
    always_comb begin
        d_step = tgt;
        if (diff_mag > STEP_W) begin
            d_step = diff[DUTY_W] ? (d_q - STEP_V) : (d_q + STEP_V);
        end
    end

    assign active    = (state_q == RAMP) || (state_q == HOLD);
    assign wdog_trip = active && !tick && (wdog_q >= WD_TRIP);

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        wdog_d  = wdog_q;

        if (fault || wdog_trip) begin
            state_d = FAULT;
            d_d     = '0;
            wdog_d  = '0;
        end else if (!ce) begin
            state_d = IDLE;
            d_d     = '0;
            wdog_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RAMP;
                    d_d     = '0;
                    wdog_d  = '0;
                end
                RAMP, HOLD: begin
                    if (tick) begin
                        d_d     = d_step;
                        wdog_d  = '0;
                        state_d = (d_step == tgt) ? HOLD : RAMP;
                    end else if (wdog_q != WD_SATMAX) begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                FAULT: begin
                    d_d    = '0;
                    wdog_d = '0;
`ifdef DUTY_RAMP_FAULT_LATCH_EN
                    state_d = FAULT;
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                    d_d     = '0;
                    wdog_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            wdog_q  <= wdog_d;
        end
    end

    assign d_halfbridge = d_q;
    assign ramp_done    = (state_q == HOLD);
    assign fault_flag   = (state_q == FAULT);

endmodule
